// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters.
// Launches one send per grant and reports done or timeout back to the owner.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = 7,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          grant,
    output logic                        tx_done,
    output logic                        tx_err,
    output logic [$clog2(NUM_REQ)-1:0]  tx_id,
    output logic                        busy,
    output logic                        uart_send,
    output logic [DATA_W-1:0]           uart_data,
    input  logic                        uart_done
);

    localparam int                   ID_W     = $clog2(NUM_REQ);
    localparam int                   CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned          NR       = NUM_REQ;
    localparam logic [ID_W-1:0]      ID_LAST  = ID_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic [ID_W-1:0]     owner;
    logic [ID_W-1:0]     last;
    logic [ID_W-1:0]     winner;
    logic                found;
    logic [DATA_W-1:0]   win_data;
    logic [CNT_W-1:0]    cnt;
    logic                timeout;

    logic [NUM_REQ-1:0]  grant_nxt;
    logic                send_nxt;
    logic                done_nxt;
    logic                err_nxt;
    logic                busy_nxt;

    // Scan last+1, last+2, ... (mod NUM_REQ); the first requesting index wins.
    always_comb begin
        int unsigned     last_u;
        logic [ID_W-1:0] idx;
        winner = '0;
        found  = 1'b0;
        last_u = 32'(last);
        idx    = '0;
        for (int unsigned i = 1; i <= NR; i++) begin
            idx = ID_W'((last_u + i) % NR);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            if (ID_W'(i) == winner) begin
                win_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign timeout = (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (found) state_nxt = GRANT;
            GRANT:   state_nxt = WAIT;
            WAIT:    if (uart_done || timeout) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Values the registered outputs take on the coming edge; a done on the
    // timeout edge reports completion rather than an error.
    always_comb begin
        grant_nxt = '0;
        send_nxt  = 1'b0;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        busy_nxt  = (state_nxt != IDLE);
        if (state == IDLE && state_nxt == GRANT) begin
            grant_nxt[winner] = 1'b1;
            send_nxt          = 1'b1;
        end
        if (state == WAIT && state_nxt == DONE) begin
            done_nxt = uart_done;
            err_nxt  = ~uart_done;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant     <= '0;
            uart_send <= 1'b0;
            tx_done   <= 1'b0;
            tx_err    <= 1'b0;
            busy      <= 1'b0;
            tx_id     <= '0;
            uart_data <= '0;
            owner     <= '0;
            last      <= ID_LAST;
            cnt       <= '0;
        end else begin
            grant     <= grant_nxt;
            uart_send <= send_nxt;
            tx_done   <= done_nxt;
            tx_err    <= err_nxt;
            busy      <= busy_nxt;
            if (state == IDLE && found) begin
                owner     <= winner;
                uart_data <= win_data;
            end
            if (state == GRANT) begin
                cnt <= '0;
            end else if (state == WAIT && !timeout) begin
                cnt <= cnt + 1'b1;
            end
            if (state == WAIT && state_nxt == DONE) begin
                tx_id <= owner;
            end
            if (state == DONE) begin
                last <= owner;
            end
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one 7-bit UART transmitter among NUM_REQ requesters using round-robin arbitration.
- Captures the winner's data and pulses the UART send input once.
- Waits for the UART's one-cycle done pulse, then reports completion or a timeout to the winning requester.
- Sits between the requester-side logic and the UART transmitter instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 7, character width; matches the UART data input
- TIMEOUT_CYCLES, 64, cycles to wait in WAIT for uart_done before aborting (≥ 16)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high
- req  input  NUM_REQ  per-requester request level
- req_data  input  NUM_REQ*DATA_W  requester i's data at bits [i*DATA_W +: DATA_W]
- grant  output  NUM_REQ  one-hot, one-cycle pulse; data captured
- tx_done  output  1  one-cycle pulse, transfer completed by the UART
- tx_err  output  1  one-cycle pulse, transfer aborted on timeout
- tx_id  output  $clog2(NUM_REQ)  owner index; valid while tx_done or tx_err is high
- busy  output  1  high in every state except IDLE
- uart_send  output  1  to the UART send input; one-cycle pulse
- uart_data  output  DATA_W  to the UART data input; held from GRANT through DONE
- uart_done  input  1  from the UART done output

Behaviour:
- All outputs are registered.
- Reset (sampled at a clk edge):
  - state=IDLE.
  - grant=0, tx_done=0, tx_err=0, tx_id=0, busy=0, uart_send=0, uart_data=0.
  - Timeout counter=0, last=NUM_REQ-1, so requester 0 has first priority.
- Reset mid-transfer aborts immediately: no tx_done or tx_err pulse, and uart_send is forced low on the next edge.
- States: IDLE, GRANT, WAIT, DONE.
- IDLE:
  - If req≠0, pick the winner by scanning indices last+1, last+2, … mod NUM_REQ; the first set bit wins.
  - On that edge: owner<=winner, uart_data<=req_data slice of winner, and go to GRANT.
  - If req==0, stay in IDLE.
- GRANT (exactly 1 cycle):
  - grant[owner]=1, uart_send=1, busy=1.
  - Next state is WAIT; timeout counter cleared.
  - Latency: req high at edge N gives grant and uart_send high during cycle N+1.
- WAIT:
  - uart_send=0, uart_data held.
  - uart_done is sampled only in WAIT; a done pulse during GRANT is ignored.
  - uart_done=1 → DONE with tx_done set.
  - Otherwise the counter increments. When the counter reaches TIMEOUT_CYCLES-1 without uart_done → DONE with tx_err set.
  - If uart_done arrives on the same edge as the timeout, done wins: tx_done=1, tx_err=0.
- DONE (exactly 1 cycle):
  - tx_done or tx_err=1, tx_id=owner, busy=1.
  - last<=owner, then go to IDLE.
- No back-to-back overlap: at least one IDLE cycle separates transfers.
- Requester handshake:
  - Hold req high and req_data stable until grant is seen.
  - req_data is only sampled on the IDLE→GRANT edge; later changes have no effect on the transfer.
  - A req still high on a later IDLE cycle is treated as a new request.
- req changes outside IDLE are ignored. A requester that drops req before being granted is simply skipped.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,2,3,0,… and no requester waits more than NUM_REQ-1 transfers.
- Index arithmetic wraps modulo NUM_REQ. The counter width is $clog2(TIMEOUT_CYCLES) and saturates in normal use because of the abort.

Test Plan:
- Single request:
  - Stimulus: req=0001, data0=7'h55; UART done returns 12 cycles after send.
  - Response: grant=0001 and uart_send for 1 cycle; uart_data=7'h55; tx_done with tx_id=0 one cycle after uart_done; busy low afterwards.
- Simultaneous requests:
  - Stimulus: req=1010 right after reset.
  - Response: requester 1 is granted first; requester 3 is granted next (req held); then requester 1 if still requesting.
- Saturation:
  - Stimulus: req=1111 held for 8 transfers.
  - Response: tx_id sequence 0,1,2,3,0,1,2,3; exactly one IDLE cycle between DONE and the next GRANT.
- Timeout:
  - Stimulus: uart_done tied low, req=0100.
  - Response: tx_err pulse with tx_id=2 exactly TIMEOUT_CYCLES cycles after entering WAIT; tx_done stays 0; the arbiter re-arbitrates afterwards.
- Done/timeout collision and stray done:
  - Stimulus 1: uart_done asserted on the timeout edge. Response: tx_done=1, tx_err=0.
  - Stimulus 2: uart_done pulsed during GRANT. Response: ignored; still waits for the real done.
- Reset mid-WAIT:
  - Stimulus: assert reset for 1 cycle while in WAIT.
  - Response: all outputs 0 next cycle, no completion pulse; next req=1000 is served ahead of requester 0 only if requester 0 is not requesting (last was reset to 3).
